// File: rtl/control_sequencer.sv
// Hardwired T-step control sequencer for the Mini SRC datapath.
// Decodes the registered state, step and IR opcode into datapath controls.
module control_sequencer #(
    parameter int          OP_W          = 5,
    parameter int          ALU_OP_W      = 5,
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned MAX_INSTR     = 0
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                run,
    input  logic [31:0]         ir,
    input  logic                con_ff,
    input  logic                mem_ready,
    output logic                Pout,
    output logic                MARen,
    output logic                MDRen,
    output logic                MDROut,
    output logic                Read,
    output logic                Write,
    output logic                IRen,
    output logic                Pen,
    output logic                PCinc,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic                BAout,
    output logic                Cout,
    output logic                Yen,
    output logic                ZLOen,
    output logic                ZLOout,
    output logic                ConIn,
    output logic                LinkIn,
    output logic [ALU_OP_W-1:0] alu_control,
    output logic [2:0]          step,
    output logic                instr_done,
    output logic                halted,
    output logic                illegal,
    output logic [31:0]         instr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [OP_W-1:0] OP_LD   = OP_W'(5'b00000);
    localparam logic [OP_W-1:0] OP_LDI  = OP_W'(5'b00001);
    localparam logic [OP_W-1:0] OP_ST   = OP_W'(5'b00010);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'b00011);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5'b00100);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(5'b01010);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(5'b01011);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5'b01100);
    localparam logic [OP_W-1:0] OP_BR   = OP_W'(5'b10010);
    localparam logic [OP_W-1:0] OP_JR   = OP_W'(5'b10011);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(5'b10100);
    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(5'b11010);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(5'b11011);

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(5'b00011);

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [31:0] count_q, count_d;

    logic [OP_W-1:0] opcode;
    logic is_alu, is_addi, is_ldi, is_ld, is_st, is_br;
    logic is_jr, is_jal, is_halt, is_known;
    logic [2:0] last_step;
    logic       mem_step;
    logic       mem_ok;
    logic       final_step;
    logic       budget_hit;

    assign opcode = ir[31:32-OP_W];

    wire unused_ir = ^ir[31-OP_W:0];

    always_comb begin
        is_alu   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_OR);
        is_addi  = (opcode == OP_ADDI);
        is_ldi   = (opcode == OP_LDI);
        is_ld    = (opcode == OP_LD);
        is_st    = (opcode == OP_ST);
        is_br    = (opcode == OP_BR);
        is_jr    = (opcode == OP_JR);
        is_jal   = (opcode == OP_JAL);
        is_halt  = (opcode == OP_HALT);
        is_known = is_alu || is_addi || is_ldi || is_ld || is_st ||
                   is_br || is_jr || is_jal || is_halt ||
                   (opcode == OP_NOP);
        last_step = 3'd3;
        unique case (1'b1)
            is_alu, is_addi, is_ldi: last_step = 3'd5;
            is_ld, is_st:            last_step = 3'd7;
            is_br:                   last_step = 3'd6;
            is_jal:                  last_step = 3'd4;
            default:                 last_step = 3'd3;
        endcase
    end

    // Unknown opcodes fall through to the 4-step nop timing.
    always_comb begin
        mem_step   = (step_q == 3'd1) ||
                     (step_q == 3'd6 && is_ld) ||
                     (step_q == 3'd7 && is_st);
        mem_ok     = !MEM_HANDSHAKE || mem_ready;
        final_step = (state_q == S_EXEC) && (step_q == last_step);
        budget_hit = (MAX_INSTR != 0) &&
                     (count_q + 32'd1 == 32'(MAX_INSTR));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            step_q  <= 3'd0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        count_d = count_q;
        unique case (state_q)
            S_IDLE: begin
                step_d = 3'd0;
                if (run) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!mem_step || mem_ok) begin
                    if (final_step) begin
                        count_d = count_q + 32'd1;
                        step_d  = 3'd0;
                        if (is_halt || budget_hit) state_d = S_HALT;
                        else if (run)              state_d = S_EXEC;
                        else                       state_d = S_IDLE;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            S_HALT: begin
                step_d = 3'd0;
            end
            default: begin
                state_d = S_IDLE;
                step_d  = 3'd0;
            end
        endcase
    end

    always_comb begin
        Pout = 1'b0; MARen = 1'b0; MDRen = 1'b0; MDROut = 1'b0;
        Read = 1'b0; Write = 1'b0; IRen = 1'b0; Pen = 1'b0;
        PCinc = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; Cout = 1'b0;
        Yen = 1'b0; ZLOen = 1'b0; ZLOout = 1'b0; ConIn = 1'b0;
        LinkIn = 1'b0;
        alu_control = '0;
        illegal     = 1'b0;
        instr_done  = final_step;
        halted      = (state_q == S_HALT);
        step        = step_q;
        instr_count = count_q;
        if (state_q == S_EXEC) begin
            unique case (step_q)
                3'd0: begin
                    Pout = 1'b1; MARen = 1'b1; PCinc = 1'b1;
                end
                3'd1: begin
                    Read = 1'b1; MDRen = 1'b1;
                end
                3'd2: begin
                    MDROut = 1'b1; IRen = 1'b1;
                end
                3'd3: begin
                    illegal = !is_known;
                    if (is_alu || is_addi) begin
                        Grb = 1'b1; Rout = 1'b1; Yen = 1'b1;
                    end
                    if (is_ldi || is_ld || is_st) begin
                        Grb = 1'b1; BAout = 1'b1; Yen = 1'b1;
                    end
                    if (is_br) begin
                        Gra = 1'b1; Rout = 1'b1; ConIn = 1'b1;
                    end
                    if (is_jr) begin
                        Gra = 1'b1; Rout = 1'b1; Pen = 1'b1;
                    end
                    if (is_jal) begin
                        Pout = 1'b1; LinkIn = 1'b1;
                    end
                end
                3'd4: begin
                    if (is_alu) begin
                        Grc = 1'b1; Rout = 1'b1; ZLOen = 1'b1;
                        alu_control = ALU_OP_W'(opcode);
                    end
                    if (is_addi || is_ldi || is_ld || is_st) begin
                        Cout = 1'b1; ZLOen = 1'b1;
                        alu_control = ALU_ADD;
                    end
                    if (is_br) begin
                        Pout = 1'b1; Yen = 1'b1;
                    end
                    if (is_jal) begin
                        Gra = 1'b1; Rout = 1'b1; Pen = 1'b1;
                    end
                end
                3'd5: begin
                    if (is_alu || is_addi || is_ldi) begin
                        ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    if (is_ld || is_st) begin
                        ZLOout = 1'b1; MARen = 1'b1;
                    end
                    if (is_br) begin
                        Cout = 1'b1; ZLOen = 1'b1;
                        alu_control = ALU_ADD;
                    end
                end
                3'd6: begin
                    if (is_ld) begin
                        Read = 1'b1; MDRen = 1'b1;
                    end
                    if (is_st) begin
                        Gra = 1'b1; Rout = 1'b1; MDRen = 1'b1;
                    end
                    if (is_br) begin
                        ZLOout = 1'b1; Pen = con_ff;
                    end
                end
                3'd7: begin
                    if (is_ld) begin
                        MDROut = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    if (is_st) Write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised hardwired control-step sequencer for the Mini SRC datapath. It generates the fetch and execute control signals as T-steps per opcode, replacing hand-driven per-instruction state machines. It sits beside `DataPath` and drives its enable, out, select and ALU-op inputs from the IR contents. It adds a memory-ready handshake, conditional branching from the CON FF, halt, and an optional instruction budget.

## Interface
Parameters:
- `OP_W`, 5: opcode width, taken from `ir[31:32-OP_W]`.
- `ALU_OP_W`, 5: width of `alu_control`.
- `MEM_HANDSHAKE`, 1: 1 = memory steps wait for `mem_ready`; 0 = `mem_ready` ignored, treated as 1.
- `MAX_INSTR`, 0: 0 = unlimited; N > 0 = enter HALTED after N completed instructions.

Ports:
- `clk` in 1: single clock, rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `run` in 1: level; start or continue fetching.
- `ir` in 32: IR register contents; valid from T3 onward.
- `con_ff` in 1: branch condition from the CON FF.
- `mem_ready` in 1: memory read/write completes this cycle.
- `Pout, MARen, MDRen, MDROut, Read, Write, IRen, Pen, PCinc, Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yen, ZLOen, ZLOout, ConIn, LinkIn` out 1 each: datapath controls.
- `alu_control` out `ALU_OP_W`: ALU operation.
- `step` out 3: current T index, 0..7.
- `instr_done` out 1: high during the final step of each instruction.
- `halted` out 1: sequencer is in HALTED.
- `illegal` out 1: high during T3 of an unknown opcode.
- `instr_count` out 32: completed instructions; wraps at 2^32.

## Operation
- States: IDLE, EXEC (step 0..7), HALTED.
- IDLE goes to EXEC step 0 on the edge where `run`=1.
- Each step lasts one cycle, except read/write steps when `MEM_HANDSHAKE`=1.
- Final step of an instruction: `instr_count`++. The next state is then:
  - HALTED if the opcode is halt or the budget is reached;
  - otherwise EXEC step 0 if `run`=1;
  - otherwise IDLE.
- Fetch:
  - T0: `Pout`, `MARen`, `PCinc`.
  - T1: `Read`, `MDRen` (memory step).
  - T2: `MDROut`, `IRen`.
- Execute; opcode encodings are binary, ALU codes are `ALU_OP_W`-bit, ADD=00011:
  - add 00011, sub 00100, and 01010, or 01011:
    - T3: `Grb`, `Rout`, `Yen`.
    - T4: `Grc`, `Rout`, `alu_control`=opcode, `ZLOen`.
    - T5: `ZLOout`, `Gra`, `Rin`; done.
  - addi 01100:
    - T3: `Grb`, `Rout`, `Yen`.
    - T4: `Cout`, ADD, `ZLOen`.
    - T5: `ZLOout`, `Gra`, `Rin`.
  - ldi 00001: same as addi, but T3 uses `BAout` instead of `Rout`.
  - ld 00000:
    - T3: `Grb`, `BAout`, `Yen`.
    - T4: `Cout`, ADD, `ZLOen`.
    - T5: `ZLOout`, `MARen`.
    - T6: `Read`, `MDRen` (memory step).
    - T7: `MDROut`, `Gra`, `Rin`.
  - st 00010:
    - T3–T5 as ld.
    - T6: `Gra`, `Rout`, `MDRen`.
    - T7: `Write` (memory step).
  - br 10010:
    - T3: `Gra`, `Rout`, `ConIn`.
    - T4: `Pout`, `Yen`.
    - T5: `Cout`, ADD, `ZLOen`.
    - T6: `ZLOout`, plus `Pen` only if `con_ff`=1.
  - jr 10011: T3: `Gra`, `Rout`, `Pen`.
  - jal 10100:
    - T3: `Pout`, `LinkIn` (R15 written).
    - T4: `Gra`, `Rout`, `Pen`.
  - nop 11010: T3 with no controls; done.
  - halt 11011: T3 with no controls; done, then HALTED.
  - any other opcode: treated as nop and asserts `illegal` during T3.
- HALTED: all controls 0 and `halted`=1; `run` is ignored. Only `clr` exits.

## Timing
- Moore outputs: a decode of the registered state, `step` and `ir`. Controls are valid the whole step cycle; the datapath loads on the edge that ends the step.
- Memory steps (T1 of all instructions, T6 of ld, T7 of st) with `MEM_HANDSHAKE`=1:
  - step advances only on an edge where `mem_ready`=1;
  - outputs are held unchanged while waiting.
- Fetch-to-done length without stalls:
  - 6 cycles: ALU ops, addi, ldi.
  - 8 cycles: ld, st.
  - 7 cycles: br.
  - 4 cycles: jr, nop, halt.
  - 5 cycles: jal.
- Back-to-back: with `run`=1, the final step is followed directly by T0 (no bubble).
- `con_ff` is sampled combinationally in br T6.
- `clr`=1 at any edge, including mid-instruction or mid-stall:
  - next cycle: IDLE, all control outputs 0, `step`=0, `alu_control`=0;
  - `instr_done`=0, `illegal`=0, `halted`=0, `instr_count`=0.
- `clr` has priority over `run`, `mem_ready` and the budget.
- Budget reached and halt opcode in the same final step: HALTED, counted once.

## Test plan
- Reset, `run`=1, `ir`=0x18918000 (add R1,R2,R3), `mem_ready`=1 → steps 0–5 in 6 cycles; T4 `alu_control`=00011; `instr_done` at T5; `instr_count`=1; next cycle `step`=0.
- ld with `mem_ready` low for 3 cycles in T1 and 2 cycles in T6 → T1 held 4 cycles and T6 held 3 cycles with outputs stable; done after 13 cycles total.
- br with `con_ff`=0, then again with `con_ff`=1 → T6 has `ZLOout`=1 and `Pen`=0 in the first case, `Pen`=1 in the second.
- halt opcode 11011 with `run`=1 → `halted`=1 after T3 and stays set for 20 cycles; `clr` pulse → IDLE, `instr_count`=0.
- `MAX_INSTR`=2, two nops with `run` held high → HALTED after the second `instr_done`; `instr_count`=2. Opcode 11111 → `illegal` high for one cycle at T3.
- `clr` asserted during ld T5 → next cycle all controls 0, `step`=0, IDLE; with `run`=1 the sequencer restarts at T0 one cycle after `clr` drops.
